// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and defaults for the AES share arbiter
package aes_arb_pkg;
  localparam int BLOCK_W_DEF = 128;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: saturating cycle counter with an expire flag
// clk/reset: clock and sync active-high reset; clear: zero the count;
// enable: count one cycle; expire: high in the cycle that completes TIMEOUT_CYCLES counted cycles
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] count;
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable && count != TW'(TIMEOUT_CYCLES)) count <= count + 1'b1;
  end
  // the current enabled cycle is the last one allowed
  assign expire = count >= TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/aes_share_arbiter.sv
// aes_share_arbiter: round-robin sharing of one AES core between two requesters
// req0/req1: valid/ready block inputs; aes_in_data/aes_start: core issue;
// aes_out_data/aes_done: core result; res0/res1: valid/ready result returns;
// owner: current/last grant, busy: not idle, timeout_err: one-cycle abort pulse
module aes_share_arbiter import aes_arb_pkg::*; #(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] req0_data,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [BLOCK_W-1:0] req1_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  output logic [BLOCK_W-1:0] aes_in_data,
  output logic               aes_start,
  input  logic [BLOCK_W-1:0] aes_out_data,
  input  logic               aes_done,
  output logic [BLOCK_W-1:0] res0_data,
  output logic               res0_valid,
  input  logic               res0_ready,
  output logic [BLOCK_W-1:0] res1_data,
  output logic               res1_valid,
  input  logic               res1_ready,
  output logic               owner,
  output logic               busy,
  output logic               timeout_err
);
  state_t state, state_n;
  req_id_t last_grant, grant;
  logic [BLOCK_W-1:0] data_q, res_q;
  logic idle, accept, done_hit, tmo_hit, res_fire, expire;
  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ISSUE),
    .enable (state == WAIT),
    .expire (expire)
  );
  always_comb begin
    idle = state == IDLE && !reset;
    grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = idle && req0_valid && grant == 1'b0;
    req1_ready = idle && req1_valid && grant == 1'b1;
    accept = req0_ready || req1_ready;
    done_hit = state == WAIT && aes_done;
    tmo_hit = state == WAIT && !aes_done && expire;
    res_fire = state == DELIVER && (owner ? res1_ready : res0_ready);
    state_n = accept ? ISSUE :
              state == ISSUE ? WAIT :
              done_hit ? DELIVER :
              (tmo_hit || res_fire) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      data_q <= '0;
      res_q <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      timeout_err <= tmo_hit;
      if (accept) begin
        data_q <= grant ? req1_data : req0_data;
        owner <= grant;
      end
      if (done_hit) res_q <= aes_out_data;
      if (tmo_hit || res_fire) last_grant <= owner;
    end
  end
  // reset gates the strobes so nothing leaks out in the reset cycle
  assign aes_start = state == ISSUE && !reset;
  assign res0_valid = state == DELIVER && !owner && !reset;
  assign res1_valid = state == DELIVER && owner && !reset;
  assign aes_in_data = data_q;
  assign res0_data = res_q;
  assign res1_data = res_q;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_aes_share_arbiter.sv
// tb_aes_share_arbiter: randomized transaction-level check of aes_share_arbiter
module tb_aes_share_arbiter;
  localparam int BW = 128;
  localparam int TO = 64;
  logic clk = 0;
  logic reset;
  logic [BW-1:0] req0_data, req1_data, aes_in_data, aes_out_data, res0_data, res1_data;
  logic req0_valid, req0_ready, req1_valid, req1_ready, aes_start, aes_done;
  logic res0_valid, res0_ready, res1_valid, res1_ready, owner, busy, timeout_err;
  always #5 clk = ~clk;
  aes_share_arbiter #(.BLOCK_W(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .aes_in_data(aes_in_data), .aes_start(aes_start),
    .aes_out_data(aes_out_data), .aes_done(aes_done),
    .res0_data(res0_data), .res0_valid(res0_valid), .res0_ready(res0_ready),
    .res1_data(res1_data), .res1_valid(res1_valid), .res1_ready(res1_ready),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );
  int n_cmp = 0;
  int n_bad = 0;
  bit pend [2];
  logic [BW-1:0] pdata [2];
  bit lg;
  function automatic logic [BW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_reqs(input bit en);
    req0_valid = en && pend[0];
    req1_valid = en && pend[1];
    req0_data = pend[0] ? pdata[0] : rnd();
    req1_data = pend[1] ? pdata[1] : rnd();
  endtask
  task automatic txn(input bit f0, input bit f1, input int lat, input int rdly,
                     input int rst_at = 0, input logic [BW-1:0] rfix = '0);
    bit id;
    logic [BW-1:0] d, r;
    @(negedge clk);
    if (f0 && !pend[0]) begin pend[0] = 1; pdata[0] = rnd(); end
    if (f1 && !pend[1]) begin pend[1] = 1; pdata[1] = rnd(); end
    id = (pend[0] && pend[1]) ? !lg : pend[1];
    d = pdata[id];
    drive_reqs(1);
    aes_done = 1'($urandom_range(0, 1));
    aes_out_data = rnd();
    res0_ready = 1'($urandom_range(0, 1));
    res1_ready = 1'($urandom_range(0, 1));
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_ready0", req0_ready, pend[0] && id == 0);
    chk("idle_ready1", req1_ready, pend[1] && id == 1);
    chk("idle_start", aes_start, 0);
    @(negedge clk);
    pend[id] = 0;
    drive_reqs(1);
    aes_done = 1'($urandom_range(0, 1));
    aes_out_data = rnd();
    #1;
    chk("issue_start", aes_start, 1);
    chk("issue_owner", owner, id);
    chk("issue_data", aes_in_data, d);
    chk("issue_ready", {req0_ready, req1_ready}, 0);
    chk("issue_res", {res0_valid, res1_valid}, 0);
    for (int k = 1; ; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        reset = 1;
        aes_done = 0;
        #1;
        chk("rst_start", aes_start, 0);
        chk("rst_res", {res0_valid, res1_valid}, 0);
        @(negedge clk);
        reset = 0;
        drive_reqs(0);
        aes_done = 1;
        aes_out_data = rnd();
        #1;
        chk("rst_late_res", {res0_valid, res1_valid}, 0);
        chk("rst_late_tmo", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        @(negedge clk);
        aes_done = 0;
        #1;
        chk("rst_after_res", {res0_valid, res1_valid, busy}, 0);
        lg = 1;
        return;
      end
      r = rfix !== '0 ? rfix : rnd();
      aes_done = k == lat;
      aes_out_data = r;
      #1;
      chk("wait_start", aes_start, 0);
      chk("wait_data", aes_in_data, d);
      chk("wait_res", {res0_valid, res1_valid}, 0);
      chk("wait_tmo", timeout_err, 0);
      chk("wait_busy", busy, 1);
      chk("wait_ready", {req0_ready, req1_ready}, 0);
      if (k == lat || (lat == 0 && k == TO)) break;
    end
    if (lat == 0) begin
      @(negedge clk);
      drive_reqs(0);
      aes_done = 1;
      aes_out_data = rnd();
      #1;
      chk("tmo_pulse", timeout_err, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_res", {res0_valid, res1_valid}, 0);
      lg = id;
      @(negedge clk);
      aes_done = 0;
      #1;
      chk("tmo_drop", timeout_err, 0);
      chk("tmo_late_res", {res0_valid, res1_valid, busy}, 0);
      return;
    end
    for (int j = 0; j <= rdly; j++) begin
      @(negedge clk);
      aes_done = 1'($urandom_range(0, 1));
      aes_out_data = rnd();
      res0_ready = id == 0 ? j == rdly : 1'($urandom_range(0, 1));
      res1_ready = id == 1 ? j == rdly : 1'($urandom_range(0, 1));
      #1;
      chk("dlv_valid", {res0_valid, res1_valid}, id ? 2'b01 : 2'b10);
      chk("dlv_data", id ? res1_data : res0_data, r);
      chk("dlv_tmo", timeout_err, 0);
      chk("dlv_busy", busy, 1);
      chk("dlv_ready", {req0_ready, req1_ready}, 0);
      chk("dlv_start", aes_start, 0);
    end
    lg = id;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    pend[0] = 0;
    pend[1] = 0;
    drive_reqs(0);
    aes_done = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_state", {aes_start, res0_valid, res1_valid, timeout_err, busy, owner}, 0);
    chk("rst_in_data", aes_in_data, 0);
    lg = 1;
  endtask
  initial begin
    reset = 1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    aes_done = 0; aes_out_data = '0; res0_ready = 0; res1_ready = 0;
    repeat (3) @(negedge clk);
    do_reset();
    pend[0] = 1;
    pdata[0] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    txn(0, 0, 1, 0, 0, {16{8'hA5}});
    do_reset();
    txn(1, 1, 1, 0);
    txn(0, 0, 2, 0);
    for (int i = 0; i < 4; i++) txn(1, 1, 1 + i, 10);
    txn(1, 0, 0, 0);
    txn(1, 1, TO, 1);
    for (int i = 0; i < 40; i++) begin
      int p;
      bit f0, f1;
      p = $urandom_range(0, 9);
      f0 = 1'($urandom_range(0, 1));
      f1 = 1'($urandom_range(0, 1));
      if (!f0 && !f1 && !pend[0] && !pend[1]) f0 = 1;
      txn(f0, f1, p == 0 ? 0 : p == 1 ? TO : $urandom_range(1, 6),
          $urandom_range(0, 5) == 0 ? 10 : $urandom_range(0, 3));
    end
    txn(1, 1, 5, 0, 3);
    txn(1, 1, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
